// File: rtl/mcpu_pkg.sv
// mcpu_pkg: shared types and constants for the multi-cycle CPU control unit.
// Holds the FSM state encoding, opcode values, ALU control codes, datapath
// mux-select codes and small decode helpers used by mcpu_ctrl and mcpu_alu_dec.
package mcpu_pkg;

    // One state per datapath cycle; encoding is visible on state_o for debug.
    typedef enum logic [3:0] {
        S_IF      = 4'd0,
        S_ID      = 4'd1,
        S_EX_R    = 4'd2,
        S_EX_I    = 4'd3,
        S_EX_ADDR = 4'd4,
        S_MEM_RD  = 4'd5,
        S_MEM_WR  = 4'd6,
        S_WB_ALU  = 4'd7,
        S_WB_LD   = 4'd8,
        S_EX_BR   = 4'd9,
        S_EX_JAL  = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    // Kind of ALU operation a state asks for; the ALU decoder turns this
    // plus the funct fields into the actual ALU_Control code.
    typedef enum logic [1:0] {
        ALU_CLS_ADD = 2'd0,
        ALU_CLS_SUB = 2'd1,
        ALU_CLS_R   = 2'd2,
        ALU_CLS_I   = 2'd3
    } alu_cls_t;

    // Opcodes as seen on inst[6:2].
    localparam logic [4:0] OP_R   = 5'b01100;
    localparam logic [4:0] OP_I   = 5'b00100;
    localparam logic [4:0] OP_LD  = 5'b00000;
    localparam logic [4:0] OP_ST  = 5'b01000;
    localparam logic [4:0] OP_BR  = 5'b11000;
    localparam logic [4:0] OP_JAL = 5'b11011;

    // ALU_Control codes.
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_XOR = 3'b011;
    localparam logic [2:0] ALU_SRL = 3'b101;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALUSrc_A selects.
    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_RS1   = 2'b01;
    localparam logic [1:0] SRCA_OLDPC = 2'b10;

    // ALUSrc_B selects.
    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_FOUR = 2'b01;
    localparam logic [1:0] SRCB_IMM  = 2'b10;

    // ImmSel selects.
    localparam logic [1:0] IMM_I  = 2'b00;
    localparam logic [1:0] IMM_S  = 2'b01;
    localparam logic [1:0] IMM_SB = 2'b10;
    localparam logic [1:0] IMM_UJ = 2'b11;

    // MemtoReg selects.
    localparam logic [1:0] MTR_ALUOUT = 2'b00;
    localparam logic [1:0] MTR_MDR    = 2'b01;
    localparam logic [1:0] MTR_PC     = 2'b10;

    // PCSource selects.
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;

    // Immediate format implied by an opcode; used while ALUOut gets OldPC+imm.
    function automatic logic [1:0] imm_sel_for(input logic [4:0] opcode);
        logic [1:0] sel;
        case (opcode)
            OP_ST:   sel = IMM_S;
            OP_BR:   sel = IMM_SB;
            OP_JAL:  sel = IMM_UJ;
            default: sel = IMM_I;
        endcase
        return sel;
    endfunction

    // Branch decision from Fun3 and the ALU zero flag of rs1-rs2.
    function automatic logic branch_taken(input logic [2:0] fun3, input logic zero);
        logic taken;
        case (fun3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/mcpu_ctrl_if.sv
// mcpu_ctrl_if: bundle of the control unit <-> datapath/MIO signals.
// master = control unit (drives selects/enables, reads IR fields and status),
// slave  = datapath side.
interface mcpu_ctrl_if;
    logic [4:0] OPcode;
    logic [2:0] Fun3;
    logic       Fun7;
    logic       Zero;
    logic       MIO_ready;

    logic       PCWrite;
    logic       IRWrite;
    logic       IorD;
    logic       MemRW;
    logic       CPU_MIO;
    logic       RegWrite;
    logic [1:0] ALUSrc_A;
    logic [1:0] ALUSrc_B;
    logic [1:0] ImmSel;
    logic [1:0] MemtoReg;
    logic [1:0] PCSource;
    logic [2:0] ALU_Control;

    modport master (
        input  OPcode, Fun3, Fun7, Zero, MIO_ready,
        output PCWrite, IRWrite, IorD, MemRW, CPU_MIO, RegWrite,
               ALUSrc_A, ALUSrc_B, ImmSel, MemtoReg, PCSource, ALU_Control
    );

    modport slave (
        output OPcode, Fun3, Fun7, Zero, MIO_ready,
        input  PCWrite, IRWrite, IorD, MemRW, CPU_MIO, RegWrite,
               ALUSrc_A, ALUSrc_B, ImmSel, MemtoReg, PCSource, ALU_Control
    );
endinterface

// File: rtl/mcpu_ctrl_alu_dec.sv
// mcpu_alu_dec: combinational ALU_Control decoder.
// Fixed add/sub for address, PC and branch-compare states; funct-driven
// decode for R-type ({Fun3,Fun7}) and I-type (Fun3 only). Unlisted
// funct combinations fall back to add.
module mcpu_alu_dec
    import mcpu_pkg::*;
(
    input  alu_cls_t   alu_cls,
    input  logic [2:0] fun3,
    input  logic       fun7,
    output logic [2:0] alu_control
);

    // Map operation class and funct fields to the ALU opcode.
    always_comb begin
        alu_control = ALU_ADD;
        case (alu_cls)
            ALU_CLS_ADD: alu_control = ALU_ADD;
            ALU_CLS_SUB: alu_control = ALU_SUB;
            ALU_CLS_R: begin
                case ({fun3, fun7})
                    4'b0000: alu_control = ALU_ADD;
                    4'b0001: alu_control = ALU_SUB;
                    4'b1110: alu_control = ALU_AND;
                    4'b1100: alu_control = ALU_OR;
                    4'b0100: alu_control = ALU_SLT;
                    4'b1010: alu_control = ALU_SRL;
                    4'b1000: alu_control = ALU_XOR;
                    default: alu_control = ALU_ADD;
                endcase
            end
            ALU_CLS_I: begin
                case (fun3)
                    3'b000:  alu_control = ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b100:  alu_control = ALU_XOR;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    3'b101:  alu_control = ALU_SRL;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcpu_ctrl.sv
// mcpu_ctrl: Moore FSM sequencing the multi-cycle RV32I-subset datapath.
// Outputs decode from the state register; MIO_ready qualifies PC/IR loads
// in IF, Zero qualifies the PC load in EX_BR. Memory states stretch until
// MIO_ready. instret counts retired instructions for the debug display.
// Optional feature macro: MCPU_ILLEGAL_TRAP_EN -- unknown opcodes enter a
// sticky TRAP state and raise `illegal`; without it they retire as NOPs.
module mcpu_ctrl
    import mcpu_pkg::*;
#(
    parameter int INSTRET_W = 32
)(
    input  logic                 clk,
    input  logic                 rst_n,
    mcpu_ctrl_if.master          bus,
    output logic [3:0]           state_o,
    output logic [INSTRET_W-1:0] instret,
    output logic                 illegal
);

    state_t                 state_r;
    state_t                 state_nxt_s;
    logic                   retire_s;
    logic [INSTRET_W-1:0]   instret_r;

    logic                   pc_write_s;
    logic                   ir_write_s;
    logic                   iord_s;
    logic                   mem_rw_s;
    logic                   cpu_mio_s;
    logic                   reg_write_s;
    logic [1:0]             alu_src_a_s;
    logic [1:0]             alu_src_b_s;
    logic [1:0]             imm_sel_s;
    logic [1:0]             mem_to_reg_s;
    logic [1:0]             pc_source_s;
    alu_cls_t               alu_cls_s;
    logic [2:0]             alu_control_s;

    // State register; reset lands in IF so the first fetch follows release.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IF;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and retire detection.
    always_comb begin
        state_nxt_s = state_r;
        retire_s    = 1'b0;
        case (state_r)
            S_IF: begin
                if (bus.MIO_ready) begin
                    state_nxt_s = S_ID;
                end else begin
                    state_nxt_s = S_IF;
                end
            end
            S_ID: begin
                case (bus.OPcode)
                    OP_R:         state_nxt_s = S_EX_R;
                    OP_I:         state_nxt_s = S_EX_I;
                    OP_LD, OP_ST: state_nxt_s = S_EX_ADDR;
                    OP_BR:        state_nxt_s = S_EX_BR;
                    OP_JAL:       state_nxt_s = S_EX_JAL;
                    default: begin
`ifdef MCPU_ILLEGAL_TRAP_EN
                        state_nxt_s = S_TRAP;
`else
                        // PC was already advanced in IF, so a NOP just retires.
                        state_nxt_s = S_IF;
                        retire_s    = 1'b1;
`endif
                    end
                endcase
            end
            S_EX_R, S_EX_I: state_nxt_s = S_WB_ALU;
            S_EX_ADDR: begin
                if (bus.OPcode == OP_ST) begin
                    state_nxt_s = S_MEM_WR;
                end else begin
                    state_nxt_s = S_MEM_RD;
                end
            end
            S_MEM_RD: begin
                if (bus.MIO_ready) begin
                    state_nxt_s = S_WB_LD;
                end else begin
                    state_nxt_s = S_MEM_RD;
                end
            end
            S_MEM_WR: begin
                if (bus.MIO_ready) begin
                    state_nxt_s = S_IF;
                    retire_s    = 1'b1;
                end else begin
                    state_nxt_s = S_MEM_WR;
                end
            end
            S_WB_ALU, S_WB_LD, S_EX_BR, S_EX_JAL: begin
                state_nxt_s = S_IF;
                retire_s    = 1'b1;
            end
            // Only reset leaves TRAP.
            S_TRAP:  state_nxt_s = S_TRAP;
            default: state_nxt_s = S_IF;
        endcase
    end

    // Moore output decode; anything a state does not drive stays 0.
    always_comb begin
        pc_write_s   = 1'b0;
        ir_write_s   = 1'b0;
        iord_s       = 1'b0;
        mem_rw_s     = 1'b0;
        cpu_mio_s    = 1'b0;
        reg_write_s  = 1'b0;
        alu_src_a_s  = SRCA_PC;
        alu_src_b_s  = SRCB_RS2;
        imm_sel_s    = IMM_I;
        mem_to_reg_s = MTR_ALUOUT;
        pc_source_s  = PCSRC_ALU;
        alu_cls_s    = ALU_CLS_ADD;
        case (state_r)
            S_IF: begin
                iord_s      = 1'b0;
                cpu_mio_s   = 1'b1;
                alu_src_a_s = SRCA_PC;
                alu_src_b_s = SRCB_FOUR;
                pc_source_s = PCSRC_ALU;
                pc_write_s  = bus.MIO_ready;
                ir_write_s  = bus.MIO_ready;
            end
            S_ID: begin
                alu_src_a_s = SRCA_OLDPC;
                alu_src_b_s = SRCB_IMM;
                imm_sel_s   = imm_sel_for(bus.OPcode);
            end
            S_EX_R: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_RS2;
                alu_cls_s   = ALU_CLS_R;
            end
            S_EX_I: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                imm_sel_s   = IMM_I;
                alu_cls_s   = ALU_CLS_I;
            end
            S_EX_ADDR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_IMM;
                imm_sel_s   = (bus.OPcode == OP_ST) ? IMM_S : IMM_I;
            end
            S_MEM_RD: begin
                iord_s    = 1'b1;
                cpu_mio_s = 1'b1;
                mem_rw_s  = 1'b0;
            end
            S_MEM_WR: begin
                iord_s    = 1'b1;
                cpu_mio_s = 1'b1;
                mem_rw_s  = 1'b1;
            end
            S_WB_ALU: begin
                mem_to_reg_s = MTR_ALUOUT;
                reg_write_s  = 1'b1;
            end
            S_WB_LD: begin
                mem_to_reg_s = MTR_MDR;
                reg_write_s  = 1'b1;
            end
            S_EX_BR: begin
                alu_src_a_s = SRCA_RS1;
                alu_src_b_s = SRCB_RS2;
                alu_cls_s   = ALU_CLS_SUB;
                pc_source_s = PCSRC_ALUOUT;
                pc_write_s  = branch_taken(bus.Fun3, bus.Zero);
            end
            S_EX_JAL: begin
                mem_to_reg_s = MTR_PC;
                reg_write_s  = 1'b1;
                pc_source_s  = PCSRC_ALUOUT;
                pc_write_s   = 1'b1;
            end
            S_TRAP:  pc_write_s = 1'b0;
            default: pc_write_s = 1'b0;
        endcase
    end

    mcpu_alu_dec u_alu_dec (
        .alu_cls     (alu_cls_s),
        .fun3        (bus.Fun3),
        .fun7        (bus.Fun7),
        .alu_control (alu_control_s)
    );

    // Retired-instruction counter; wraps naturally at 2^INSTRET_W.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instret_r <= {INSTRET_W{1'b0}};
        end else if (retire_s) begin
            instret_r <= instret_r + INSTRET_W'(1);
        end else begin
            instret_r <= instret_r;
        end
    end

`ifdef MCPU_ILLEGAL_TRAP_EN
    logic illegal_r;

    // Sticky flag set on the edge that enters TRAP, cleared only by reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            illegal_r <= 1'b0;
        end else if (state_nxt_s == S_TRAP) begin
            illegal_r <= 1'b1;
        end else begin
            illegal_r <= illegal_r;
        end
    end

    assign illegal = illegal_r;
`else
    assign illegal = 1'b0;
`endif

    // Enables are held off while reset is asserted, even though the state
    // register already reads IF during reset.
    assign bus.PCWrite     = pc_write_s  & rst_n;
    assign bus.IRWrite     = ir_write_s  & rst_n;
    assign bus.RegWrite    = reg_write_s & rst_n;
    assign bus.MemRW       = mem_rw_s    & rst_n;
    assign bus.CPU_MIO     = cpu_mio_s   & rst_n;
    assign bus.IorD        = iord_s;
    assign bus.ALUSrc_A    = alu_src_a_s;
    assign bus.ALUSrc_B    = alu_src_b_s;
    assign bus.ImmSel      = imm_sel_s;
    assign bus.MemtoReg    = mem_to_reg_s;
    assign bus.PCSource    = pc_source_s;
    assign bus.ALU_Control = alu_control_s;

    assign state_o = state_r;
    assign instret = instret_r;

endmodule

// File: tb/tb_mcpu_ctrl.sv
// tb_mcpu_ctrl: directed self-checking bench for mcpu_ctrl.
// Inputs change half a cycle before the rising edge; outputs are checked
// 1ns after the input change, well away from the rising edge.
module tb_mcpu_ctrl;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  state_o;
    logic [31:0] instret;
    logic        illegal;
    logic [31:0] exp_instret;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    mcpu_ctrl_if bus ();

    mcpu_ctrl #(.INSTRET_W(32)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .state_o (state_o),
        .instret (instret),
        .illegal (illegal)
    );

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        bus.OPcode = 5'b01100; bus.Fun3 = 3'b000; bus.Fun7 = 1'b0;
        bus.Zero = 1'b0; bus.MIO_ready = 1'b1;
        repeat (2) tick();
        tests++; if (state_o !== 4'd0) begin fails++; $display("FAIL reset_state: got %0d expected 0", state_o); end
        tests++; if (instret !== 32'd0) begin fails++; $display("FAIL reset_instret: got %0d expected 0", instret); end
        tests++; if (illegal !== 1'b0) begin fails++; $display("FAIL reset_illegal: got %b expected 0", illegal); end
        tests++; if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRW, bus.CPU_MIO} !== 5'b00000) begin
            fails++; $display("FAIL reset_enables_forced: got %b expected 00000",
                {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRW, bus.CPU_MIO}); end
        rst_n = 1'b1;
        #1;
        tests++; if ({bus.CPU_MIO, bus.IorD, bus.PCWrite, bus.IRWrite} !== 4'b1011) begin
            fails++; $display("FAIL first_fetch: got %b expected 1011", {bus.CPU_MIO, bus.IorD, bus.PCWrite, bus.IRWrite}); end
        tests++; if ({bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control} !== 7'b0001010) begin
            fails++; $display("FAIL fetch_alu_pc4: got %b expected 0001010", {bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control}); end
        exp_instret = 32'd0;
    endtask

    // R-type and I-type funct decode, each as a full 4-cycle instruction.
    task automatic test_alu_ops();
        logic [3:0] r_in  [0:7];
        logic [2:0] r_exp [0:7];
        logic [2:0] i_in  [0:6];
        logic [2:0] i_exp [0:6];
        r_in  = '{4'b0000, 4'b0001, 4'b1110, 4'b1100, 4'b0100, 4'b1010, 4'b1000, 4'b0110};
        r_exp = '{3'b010, 3'b110, 3'b000, 3'b001, 3'b111, 3'b101, 3'b011, 3'b010};
        i_in  = '{3'b000, 3'b010, 3'b100, 3'b110, 3'b111, 3'b101, 3'b001};
        i_exp = '{3'b010, 3'b111, 3'b011, 3'b001, 3'b000, 3'b101, 3'b010};
        for (int i = 0; i < 15; i++) begin
            logic       is_r;
            logic [2:0] exp_alu;
            is_r = (i < 8);
            bus.MIO_ready = 1'b1;
            if (is_r) begin
                bus.OPcode = 5'b01100; bus.Fun3 = r_in[i][3:1]; bus.Fun7 = r_in[i][0]; exp_alu = r_exp[i];
            end else begin
                bus.OPcode = 5'b00100; bus.Fun3 = i_in[i-8]; bus.Fun7 = 1'b1; exp_alu = i_exp[i-8];
            end
            #1;
            tests++; if ({state_o, bus.PCWrite, bus.IRWrite} !== 6'b000011) begin
                fails++; $display("FAIL alu%0d_if: got %b expected 000011", i, {state_o, bus.PCWrite, bus.IRWrite}); end
            tick();
            tests++; if ({state_o, bus.ALUSrc_A, bus.ALUSrc_B, bus.ImmSel, bus.RegWrite} !== 11'b0001_10_10_00_0) begin
                fails++; $display("FAIL alu%0d_id: got %b expected 00011010000", i,
                    {state_o, bus.ALUSrc_A, bus.ALUSrc_B, bus.ImmSel, bus.RegWrite}); end
            tick();
            tests++; if (state_o !== (is_r ? 4'd2 : 4'd3)) begin
                fails++; $display("FAIL alu%0d_ex_state: got %0d expected %0d", i, state_o, is_r ? 2 : 3); end
            tests++; if (bus.ALU_Control !== exp_alu) begin
                fails++; $display("FAIL alu%0d_control: got %b expected %b", i, bus.ALU_Control, exp_alu); end
            tests++; if ({bus.ALUSrc_A, bus.ALUSrc_B, bus.RegWrite} !== {2'b01, (is_r ? 2'b00 : 2'b10), 1'b0}) begin
                fails++; $display("FAIL alu%0d_ex_srcs: got %b", i, {bus.ALUSrc_A, bus.ALUSrc_B, bus.RegWrite}); end
            tick();
            tests++; if ({state_o, bus.RegWrite, bus.MemtoReg} !== 7'b0111_1_00) begin
                fails++; $display("FAIL alu%0d_wb: got %b expected 0111100", i, {state_o, bus.RegWrite, bus.MemtoReg}); end
            tests++; if (instret !== exp_instret) begin
                fails++; $display("FAIL alu%0d_instret_before: got %0d expected %0d", i, instret, exp_instret); end
            tick();
            exp_instret = exp_instret + 32'd1;
            tests++; if ({state_o, instret} !== {4'd0, exp_instret}) begin
                fails++; $display("FAIL alu%0d_retire: state %0d instret %0d expected state 0 instret %0d", i, state_o, instret, exp_instret); end
        end
    endtask

    task automatic test_fetch_wait();
        bus.OPcode = 5'b01100; bus.Fun3 = 3'b000; bus.Fun7 = 1'b0; bus.MIO_ready = 1'b0;
        #1;
        for (int k = 0; k < 2; k++) begin
            tests++; if ({state_o, bus.PCWrite, bus.IRWrite, bus.CPU_MIO} !== 7'b0000_001) begin
                fails++; $display("FAIL fetch_wait%0d: got %b expected 0000001", k, {state_o, bus.PCWrite, bus.IRWrite, bus.CPU_MIO}); end
            tick();
        end
        bus.MIO_ready = 1'b1;
        #1;
        tests++; if ({state_o, bus.PCWrite, bus.IRWrite} !== 6'b000011) begin
            fails++; $display("FAIL fetch_wait_done: got %b expected 000011", {state_o, bus.PCWrite, bus.IRWrite}); end
        tick();
        tests++; if (state_o !== 4'd1) begin fails++; $display("FAIL fetch_wait_id: got %0d expected 1", state_o); end
        repeat (3) tick();
        exp_instret = exp_instret + 32'd1;
        tests++; if ({state_o, instret} !== {4'd0, exp_instret}) begin
            fails++; $display("FAIL fetch_wait_retire: state %0d instret %0d expected 0/%0d", state_o, instret, exp_instret); end
    endtask

    task automatic test_load_wait();
        bus.OPcode = 5'b00000; bus.Fun3 = 3'b010; bus.Fun7 = 1'b0; bus.MIO_ready = 1'b1;
        #1;
        tests++; if (state_o !== 4'd0) begin fails++; $display("FAIL ld_if: got %0d expected 0", state_o); end
        tick();
        bus.MIO_ready = 1'b0;   // ignored outside IF/MEM states
        #1;
        tests++; if ({state_o, bus.ImmSel} !== 6'b0001_00) begin
            fails++; $display("FAIL ld_id: got %b expected 000100", {state_o, bus.ImmSel}); end
        tick();
        tests++; if ({state_o, bus.ImmSel, bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control} !== 13'b0100_00_01_10_010) begin
            fails++; $display("FAIL ld_ex_addr: got %b expected 0100000110010",
                {state_o, bus.ImmSel, bus.ALUSrc_A, bus.ALUSrc_B, bus.ALU_Control}); end
        tick();
        for (int k = 0; k < 4; k++) begin
            bus.MIO_ready = (k == 3) ? 1'b1 : 1'b0;
            #1;
            tests++; if ({state_o, bus.IorD, bus.CPU_MIO, bus.MemRW, bus.RegWrite} !== 8'b0101_1100) begin
                fails++; $display("FAIL ld_mem_rd%0d: got %b expected 01011100", k,
                    {state_o, bus.IorD, bus.CPU_MIO, bus.MemRW, bus.RegWrite}); end
            tick();
        end
        tests++; if ({state_o, bus.MemtoReg, bus.RegWrite} !== 7'b1000_01_1) begin
            fails++; $display("FAIL ld_wb: got %b expected 1000011", {state_o, bus.MemtoReg, bus.RegWrite}); end
        tick();
        exp_instret = exp_instret + 32'd1;
        tests++; if ({state_o, instret} !== {4'd0, exp_instret}) begin
            fails++; $display("FAIL ld_retire: state %0d instret %0d expected 0/%0d", state_o, instret, exp_instret); end
    endtask

    task automatic test_branch();
        logic [2:0] f3   [0:3];
        logic       zr   [0:3];
        logic       exp_pw [0:3];
        f3 = '{3'b000, 3'b000, 3'b001, 3'b001};
        zr = '{1'b1, 1'b0, 1'b0, 1'b1};
        exp_pw = '{1'b1, 1'b0, 1'b1, 1'b0};
        for (int i = 0; i < 4; i++) begin
            bus.OPcode = 5'b11000; bus.Fun3 = f3[i]; bus.Zero = zr[i]; bus.MIO_ready = 1'b1;
            #1;
            tests++; if ({state_o, bus.PCWrite} !== 5'b0000_1) begin
                fails++; $display("FAIL br%0d_if: got %b expected 00001", i, {state_o, bus.PCWrite}); end
            tick();
            tests++; if ({state_o, bus.ImmSel} !== 6'b0001_10) begin
                fails++; $display("FAIL br%0d_id: got %b expected 000110", i, {state_o, bus.ImmSel}); end
            tick();
            tests++; if (state_o !== 4'd9) begin fails++; $display("FAIL br%0d_state: got %0d expected 9", i, state_o); end
            tests++; if (bus.PCWrite !== exp_pw[i]) begin
                fails++; $display("FAIL br%0d_pcwrite: got %b expected %b", i, bus.PCWrite, exp_pw[i]); end
            tests++; if ({bus.PCSource, bus.ALU_Control, bus.RegWrite} !== 6'b01_110_0) begin
                fails++; $display("FAIL br%0d_ctrl: got %b expected 011100", i, {bus.PCSource, bus.ALU_Control, bus.RegWrite}); end
            tick();
            exp_instret = exp_instret + 32'd1;
            tests++; if ({state_o, instret} !== {4'd0, exp_instret}) begin
                fails++; $display("FAIL br%0d_retire: state %0d instret %0d expected 0/%0d", i, state_o, instret, exp_instret); end
        end
        bus.Zero = 1'b0;
    endtask

    task automatic test_jal();
        bus.OPcode = 5'b11011; bus.Fun3 = 3'b000; bus.MIO_ready = 1'b1;
        #1;
        tick();
        tests++; if ({state_o, bus.ImmSel} !== 6'b0001_11) begin
            fails++; $display("FAIL jal_id: got %b expected 000111", {state_o, bus.ImmSel}); end
        tick();
        tests++; if ({state_o, bus.MemtoReg, bus.RegWrite, bus.PCSource, bus.PCWrite} !== 10'b1010_10_1_01_1) begin
            fails++; $display("FAIL jal_ex: got %b expected 1010101011",
                {state_o, bus.MemtoReg, bus.RegWrite, bus.PCSource, bus.PCWrite}); end
        tick();
        exp_instret = exp_instret + 32'd1;
        tests++; if ({state_o, instret} !== {4'd0, exp_instret}) begin
            fails++; $display("FAIL jal_retire: state %0d instret %0d expected 0/%0d", state_o, instret, exp_instret); end
    endtask

    task automatic test_illegal();
        bus.OPcode = 5'b11111; bus.MIO_ready = 1'b1;
        #1;
        tick();
        tests++; if ({state_o, illegal} !== 5'b0001_0) begin
            fails++; $display("FAIL ill_id: got %b expected 00010", {state_o, illegal}); end
        tick();
`ifdef MCPU_ILLEGAL_TRAP_EN
        for (int k = 0; k < 10; k++) begin
            bus.MIO_ready = k[0];
            #1;
            tests++; if ({state_o, illegal, instret} !== {4'd11, 1'b1, exp_instret}) begin
                fails++; $display("FAIL ill_trap%0d: state %0d illegal %b instret %0d expected 11/1/%0d", k, state_o, illegal, instret, exp_instret); end
            tests++; if ({bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRW, bus.CPU_MIO} !== 5'b00000) begin
                fails++; $display("FAIL ill_trap_en%0d: got %b expected 00000", k,
                    {bus.PCWrite, bus.IRWrite, bus.RegWrite, bus.MemRW, bus.CPU_MIO}); end
            tick();
        end
        rst_n = 1'b0;
        #1;
        tests++; if ({state_o, illegal, instret} !== {4'd0, 1'b0, 32'd0}) begin
            fails++; $display("FAIL ill_reset: state %0d illegal %b instret %0d expected 0/0/0", state_o, illegal, instret); end
        tick();
        rst_n = 1'b1;
        bus.MIO_ready = 1'b1;
        exp_instret = 32'd0;
        #1;
`else
        exp_instret = exp_instret + 32'd1;
        tests++; if ({state_o, illegal, instret} !== {4'd0, 1'b0, exp_instret}) begin
            fails++; $display("FAIL ill_nop: state %0d illegal %b instret %0d expected 0/0/%0d", state_o, illegal, instret, exp_instret); end
`endif
    endtask

    task automatic test_store_reset();
        bus.OPcode = 5'b01000; bus.Fun3 = 3'b010; bus.MIO_ready = 1'b1;
        #1;
        tick();
        tests++; if ({state_o, bus.ImmSel} !== 6'b0001_01) begin
            fails++; $display("FAIL st_id: got %b expected 000101", {state_o, bus.ImmSel}); end
        tick();
        tests++; if ({state_o, bus.ImmSel} !== 6'b0100_01) begin
            fails++; $display("FAIL st_ex_addr: got %b expected 010001", {state_o, bus.ImmSel}); end
        tick();
        tests++; if ({state_o, bus.IorD, bus.CPU_MIO, bus.MemRW} !== 7'b0110_111) begin
            fails++; $display("FAIL st_mem_wr: got %b expected 0110111", {state_o, bus.IorD, bus.CPU_MIO, bus.MemRW}); end
        tick();
        exp_instret = exp_instret + 32'd1;
        tests++; if ({state_o, instret} !== {4'd0, exp_instret}) begin
            fails++; $display("FAIL st_retire: state %0d instret %0d expected 0/%0d", state_o, instret, exp_instret); end
        // Second store: stall in MEM_WR, then reset mid-wait.
        repeat (3) tick();
        bus.MIO_ready = 1'b0;
        #1;
        tests++; if ({state_o, bus.CPU_MIO, bus.MemRW} !== 6'b0110_11) begin
            fails++; $display("FAIL st_wait0: got %b expected 011011", {state_o, bus.CPU_MIO, bus.MemRW}); end
        tick();
        tests++; if ({state_o, bus.CPU_MIO, bus.MemRW} !== 6'b0110_11) begin
            fails++; $display("FAIL st_wait1: got %b expected 011011", {state_o, bus.CPU_MIO, bus.MemRW}); end
        rst_n = 1'b0;
        #1;
        tests++; if ({bus.MemRW, bus.CPU_MIO, state_o, instret} !== {2'b00, 4'd0, 32'd0}) begin
            fails++; $display("FAIL st_reset_async: memrw %b mio %b state %0d instret %0d expected 0/0/0/0",
                bus.MemRW, bus.CPU_MIO, state_o, instret); end
        tick();
        rst_n = 1'b1;
        #1;
        exp_instret = 32'd0;
        tests++; if ({state_o, instret, bus.CPU_MIO, bus.MemRW} !== {4'd0, exp_instret, 2'b10}) begin
            fails++; $display("FAIL st_after_release: state %0d instret %0d mio %b memrw %b expected 0/0/1/0",
                state_o, instret, bus.CPU_MIO, bus.MemRW); end
    endtask

    initial begin
        test_reset();
        test_alu_ops();
        test_fetch_wait();
        test_load_wait();
        test_branch();
        test_jal();
        test_illegal();
        test_store_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
